// File: rtl/caliptra_prim_edge_event_queue.sv
// Edge event queue: latches enabled edge pulses as pending events,
// serialises them one per cycle into a FIFO, counts coalesced pulses.
module caliptra_prim_edge_event_queue #(
  parameter int Width = 4,
  parameter int Depth = 4,
  parameter int CntW  = 8,
  localparam int IdxW = (Width > 1) ? $clog2(Width) : 1,
  localparam int PtrW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] posedge_i,
  input  logic [Width-1:0] negedge_i,
  input  logic [Width-1:0] pos_en_i,
  input  logic [Width-1:0] neg_en_i,
  input  logic             clear_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic             evt_neg_o,
  output logic [IdxW-1:0]  evt_idx_o,
  output logic [PtrW-1:0]  fifo_cnt_o,
  output logic [CntW-1:0]  drop_cnt_o
);

  localparam int SumW = CntW + IdxW + 2;

  logic [Width-1:0] pend_pos_q, pend_pos_d;
  logic [Width-1:0] pend_neg_q, pend_neg_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  drop_q, drop_d;
  logic [IdxW:0]    mem_q [Depth];
  logic [IdxW:0]    mem_d [Depth];

  logic [Width-1:0] pos_pulse, neg_pulse;
  logic [Width-1:0] drain_pos, drain_neg;
  logic [Width-1:0] drop_pos, drop_neg;
  logic [SumW-1:0]  drop_sum;
  logic [IdxW:0]    head;
  logic [IdxW-1:0]  sel_idx;
  logic             sel_vld, sel_neg;
  logic             empty, full, pop, push;

  assign pos_pulse = posedge_i & pos_en_i;
  assign neg_pulse = negedge_i & neg_en_i;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                 (wptr_q[PtrW-2:0] == rptr_q[PtrW-2:0]);
  assign pop   = !empty && evt_ready_i;
  assign push  = sel_vld && (!full || pop);

  // Descending scan so the lowest index, posedge first, wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_neg = 1'b0;
    sel_idx = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (pend_neg_q[i]) begin
        sel_vld = 1'b1;
        sel_neg = 1'b1;
        sel_idx = IdxW'(i);
      end
      if (pend_pos_q[i]) begin
        sel_vld = 1'b1;
        sel_neg = 1'b0;
        sel_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    drain_pos = '0;
    drain_neg = '0;
    if (push) begin
      if (sel_neg) drain_neg[sel_idx] = 1'b1;
      else         drain_pos[sel_idx] = 1'b1;
    end
  end

  assign drop_pos = pos_pulse & pend_pos_q & ~drain_pos;
  assign drop_neg = neg_pulse & pend_neg_q & ~drain_neg;

  always_comb begin
    drop_sum = SumW'(drop_q);
    for (int i = 0; i < Width; i++) begin
      drop_sum = drop_sum + SumW'(drop_pos[i]) + SumW'(drop_neg[i]);
    end
  end

  always_comb begin
    pend_pos_d = (pend_pos_q & ~drain_pos) | pos_pulse;
    pend_neg_d = (pend_neg_q & ~drain_neg) | neg_pulse;
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
    drop_d     = (drop_sum > SumW'({CntW{1'b1}})) ?
                 {CntW{1'b1}} : drop_sum[CntW-1:0];
    mem_d      = mem_q;
    if (push) mem_d[wptr_q[PtrW-2:0]] = {sel_neg, sel_idx};
    // Flush drops same-cycle pulses and pops as well.
    if (clear_i) begin
      pend_pos_d = '0;
      pend_neg_d = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      drop_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_pos_q <= '0;
      pend_neg_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      drop_q     <= '0;
    end else begin
      pend_pos_q <= pend_pos_d;
      pend_neg_q <= pend_neg_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head        = mem_q[rptr_q[PtrW-2:0]];
  assign evt_valid_o = !empty;
  assign evt_neg_o   = !empty && head[IdxW];
  assign evt_idx_o   = empty ? '0 : head[IdxW-1:0];
  assign fifo_cnt_o  = wptr_q - rptr_q;
  assign drop_cnt_o  = drop_q;

endmodule
